irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
// External interrupt controller driving the CP0 interrupt input. Edge-detects up to
// N_SRC synchronous interrupt lines, latches them as pending, and applies a software mask.
// It picks the highest-priority source and raises ir_out to CP0. It tracks the CP0 take and
// ERET handshake, so only one interrupt is in service at a time.
// PARAMETERS
// N_SRC       8           number of interrupt source lines (2..32)
// ID_W        3           width of source id, = clog2(N_SRC)
// MASK_RST    8'hFF       reset value of mask register (1 = source enabled)
// ACK_TMO     16          cycles in REQ without ir_ack before request is withdrawn and retried
// PORTS
// clk         in   1      main clock
// rst         in   1      synchronous reset, active-high
// irq_src     in   N_SRC  source lines, synchronous to clk; rising edge = request
// mask_we     in   1      write enable for mask register
// mask_wdata  in   N_SRC  new mask value
// mask        out  N_SRC  current mask register
// pending     out  N_SRC  latched, not yet claimed requests
// ir_out      out  1      interrupt request to CP0 ir_in
// ir_ack      in   1      CP0 took the interrupt (jump_en high for an interrupt, not ERET)
// eret        in   1      CP0 executed ERET; ends current service
// cur_valid   out  1      an interrupt is being requested or serviced
// cur_id      out  ID_W   id of the requested or serviced source
// BEHAVIOUR
// Reset (registered, next edge): mask=MASK_RST, pending=0, irq_prev=0, ir_out=0, cur_valid=0,
//   cur_id=0, state=IDLE, tmo_cnt=0. Reset dominates every other input in the same cycle.
// Edge detect: irq_prev<=irq_src each cycle; new[i]=irq_src[i]&~irq_prev[i]. A level held
//   high raises only one request.
// pending[i] <= (pending[i] & ~clr[i]) | new[i]. clr is one-hot at cur_id on REQ->SERVICE.
//   If clr and new hit the same bit in one cycle, set wins and the new request is kept.
// Mask: mask_we loads mask_wdata at the edge. The new value is seen by arbitration next cycle.
//   Masked sources still latch pending; they become eligible when unmasked.
// eligible = pending & mask. Winner = lowest set index (bit 0 highest priority).
// FSM, state registered, outputs registered:
//   IDLE:    if |eligible -> REQ; cur_id<=winner, cur_valid<=1, ir_out<=1, tmo_cnt<=0.
//            This gives 1 cycle from pending edge to ir_out.
//   REQ:     ir_out held high. Exit conditions are checked in order:
//            ir_ack -> SERVICE; ir_out<=0; pending[cur_id] cleared.
//            !mask[cur_id] (masked while requesting) -> IDLE; ir_out<=0, cur_valid<=0; pending kept.
//            tmo_cnt==ACK_TMO-1 -> IDLE; ir_out<=0, cur_valid<=0; pending kept (re-arbitrated).
//            else tmo_cnt<=tmo_cnt+1.
//            cur_id is frozen in REQ; a higher-priority arrival waits until the next IDLE.
//   SERVICE: ir_out=0, cur_valid=1. eret -> IDLE; cur_valid<=0. Re-arbitration happens next cycle,
//            so there is a minimum 1 IDLE cycle between services.
// ir_ack in IDLE/SERVICE and eret in IDLE/REQ are ignored; pending is unchanged.
// ir_ack and eret in the same cycle: only the term valid for the current state acts.
// No nesting; a new request during SERVICE stays pending.
// Mask writes during SERVICE do not affect the current service.
// TESTING
// 1 reset, then irq_src[3] 0->1 -> pending=8'h08 next edge; ir_out=1, cur_id=3 one edge later.
// 2 hold ir_ack=0 for ACK_TMO cycles -> ir_out falls, pending[3] stays 1, ir_out re-asserts
//   after 1 IDLE cycle.
// 3 edges on src 5 and src 2 same cycle -> cur_id=2 first. Ack + eret -> cur_id=5 served next.
//   pending ends 0.
// 4 in SERVICE of src 2, new edge on src 2 and src 0 -> both pending, ir_out stays 0 until eret.
//   Then cur_id=0.
// 5 in REQ for src 4, mask_we with mask=8'hEF -> ir_out drops within 2 cycles, pending[4]=1.
//   Unmask -> request re-raised.
// 6 rst asserted in SERVICE with pending=8'h81 -> next edge: all outputs and pending zero,
//   mask=MASK_RST.

Source files
------------

// File: rtl/irq_ctrl.sv
// External interrupt controller feeding the CP0 interrupt input: edge-detected sources,
// software mask, fixed priority (bit 0 highest), and one interrupt in service at a time.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate eligible sources
// REQ     | ir_out high for cur_id, waiting for CP0 to take it
// SERVICE | CP0 is running the handler for cur_id; waiting for ERET
module irq_ctrl #(
  parameter int                 N_SRC    = 8,
  parameter int                 ID_W     = 3,
  parameter logic [N_SRC-1:0]   MASK_RST = {N_SRC{1'b1}},
  parameter int                 ACK_TMO  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  output logic [N_SRC-1:0]  mask,
  output logic [N_SRC-1:0]  pending,
  output logic              ir_out,
  input  logic              ir_ack,
  input  logic              eret,
  output logic              cur_valid,
  output logic [ID_W-1:0]   cur_id
);

  localparam int TMO_W = $clog2(ACK_TMO) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [N_SRC-1:0]   irq_prev;
  logic [N_SRC-1:0]   new_req;
  logic [N_SRC-1:0]   clr;
  logic [N_SRC-1:0]   eligible;
  logic [ID_W-1:0]    winner;
  logic [TMO_W-1:0]   tmo_cnt;

  assign new_req  = irq_src & ~irq_prev;
  assign eligible = pending & mask;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state == REQ && ir_ack) clr[cur_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= MASK_RST;
      pending   <= '0;
      irq_prev  <= '0;
      ir_out    <= 1'b0;
      cur_valid <= 1'b0;
      cur_id    <= '0;
      state     <= IDLE;
      tmo_cnt   <= '0;
    end else begin
      irq_prev <= irq_src;
      // A fresh edge on the bit being claimed survives the clear.
      pending  <= (pending & ~clr) | new_req;
      if (mask_we) mask <= mask_wdata;

      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= REQ;
            cur_id    <= winner;
            cur_valid <= 1'b1;
            ir_out    <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        REQ: begin
          if (ir_ack) begin
            state  <= SERVICE;
            ir_out <= 1'b0;
          end else if (!mask[cur_id]) begin
            state     <= IDLE;
            ir_out    <= 1'b0;
            cur_valid <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            ir_out    <= 1'b0;
            cur_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        SERVICE: begin
          if (eret) begin
            state     <= IDLE;
            cur_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ir_out    <= 1'b0;
          cur_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
